// File: rtl/brick_wall_pkg.sv
// Shared constants, FSM encoding and distance helper for the breakout brick wall.
// The ball radius, brick half-sizes and screen limits live here so other game blocks agree.
package brick_wall_pkg;

    localparam int R_BALL   = 8;
    localparam int W_BLOCK  = 56;
    localparam int H_BLOCK  = 8;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HIT  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Signed 11-bit difference so coordinates left of or above a centre never wrap.
    function automatic logic [10:0] abs_diff(input logic [9:0] p, input logic [10:0] c);
        logic signed [10:0] d;
        d = $signed({1'b0, p}) - $signed(c);
        return d[10] ? 11'(-d) : 11'(d);
    endfunction

endpackage

// File: rtl/brick_hit_check.sv
// Collision test between the ball and a single brick selected by column/row.
module brick_hit_check #(
    parameter int X0      = 64,
    parameter int Y0      = 40,
    parameter int PITCH_X = 128,
    parameter int PITCH_Y = 24
) (
    input  logic [3:0] col,
    input  logic [1:0] row,
    input  logic [9:0] x_ball,
    input  logic [9:0] y_ball,
    input  logic       live,
    output logic       collide,
    output logic       side
);
    import brick_wall_pkg::*;

    logic [10:0] xc;
    logic [10:0] yc;
    logic [10:0] adx;
    logic [10:0] ady;

    // A hit beyond the brick's half-width means the ball struck an end face.
    always_comb begin
        xc      = 11'(X0) + 11'(col) * 11'(PITCH_X);
        yc      = 11'(Y0) + 11'(row) * 11'(PITCH_Y);
        adx     = abs_diff(x_ball, xc);
        ady     = abs_diff(y_ball, yc);
        collide = live && (adx <= 11'(W_BLOCK + R_BALL)) && (ady <= 11'(H_BLOCK + R_BALL));
        side    = (adx > 11'(W_BLOCK));
    end

endmodule

// File: rtl/brick_wall.sv
// Brick wall for breakout: registered per-pixel brick rendering and a sequential
// collision scanner that destroys at most one brick per ball position.
module brick_wall #(
    parameter int  COLS    = 5,
    parameter int  ROWS    = 3,
    parameter int  X0      = 64,
    parameter int  Y0      = 40,
    parameter int  PITCH_X = 128,
    parameter int  PITCH_Y = 24,
    localparam int NBRICK  = COLS * ROWS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [9:0]        x_ball,
    input  logic [9:0]        y_ball,
    input  logic [9:0]        next_x,
    input  logic [9:0]        next_y,
    output logic              brick_px,
    output logic [1:0]        brick_row,
    output logic              hit_block,
    output logic              hit_side,
    output logic [3:0]        hit_index,
    output logic [NBRICK-1:0] alive,
    output logic              endgame
);
    import brick_wall_pkg::*;

    state_t     state;
    state_t     state_next;
    logic [3:0] scan_idx;
    logic [3:0] scan_col;
    logic [1:0] scan_row;
    logic [9:0] x_latch;
    logic [9:0] y_latch;
    logic       ball_moved;
    logic       last_brick;
    logic       collide;
    logic       side;
    logic       px_hit;
    logic [1:0] px_row;

    // The scanner tests the latched position, so ball motion mid-scan is ignored.
    brick_hit_check #(
        .X0      (X0),
        .Y0      (Y0),
        .PITCH_X (PITCH_X),
        .PITCH_Y (PITCH_Y)
    ) u_check (
        .col     (scan_col),
        .row     (scan_row),
        .x_ball  (x_latch),
        .y_ball  (y_latch),
        .live    (alive[scan_idx]),
        .collide (collide),
        .side    (side)
    );

    assign ball_moved = (x_ball != x_latch) || (y_ball != y_latch);
    assign last_brick = (scan_idx == 4'(NBRICK - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start && !endgame && ball_moved) state_next = SCAN;
            SCAN: begin
                if (!start)          state_next = IDLE;
                else if (collide)    state_next = HIT;
                else if (last_brick) state_next = IDLE;
            end
            HIT:     state_next = start ? DONE : IDLE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        hit_block = 1'b0;
        if (state == HIT) hit_block = start;
    end

    // Brick removal and hit reporting happen on entry to HIT so they line up with the pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alive     <= '1;
            endgame   <= 1'b0;
            hit_side  <= 1'b0;
            hit_index <= '0;
            x_latch   <= 10'h3FF;
            y_latch   <= 10'h3FF;
            scan_idx  <= '0;
            scan_col  <= '0;
            scan_row  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!start) begin
                        alive   <= '1;
                        endgame <= 1'b0;
                    end else if (state_next == SCAN) begin
                        x_latch  <= x_ball;
                        y_latch  <= y_ball;
                        scan_idx <= '0;
                        scan_col <= '0;
                        scan_row <= '0;
                    end
                end
                SCAN: begin
                    if (state_next == HIT) begin
                        alive[scan_idx] <= 1'b0;
                        hit_side        <= side;
                        hit_index       <= scan_idx;
                    end else if (scan_col == 4'(COLS - 1)) begin
                        scan_col <= '0;
                        scan_row <= scan_row + 2'd1;
                        scan_idx <= scan_idx + 4'd1;
                    end else begin
                        scan_col <= scan_col + 4'd1;
                        scan_idx <= scan_idx + 4'd1;
                    end
                end
                DONE: if (start && (alive == '0)) endgame <= 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        logic [3:0] bi;
        px_hit = 1'b0;
        px_row = '0;
        bi     = '0;
        if ((next_x < 10'(SCREEN_W)) && (next_y < 10'(SCREEN_H))) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    bi = 4'(r * COLS + c);
                    if (alive[bi]
                        && (abs_diff(next_x, 11'(X0 + c * PITCH_X)) <= 11'(W_BLOCK))
                        && (abs_diff(next_y, 11'(Y0 + r * PITCH_Y)) <= 11'(H_BLOCK))) begin
                        px_hit = 1'b1;
                        px_row = 2'(r);
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            brick_px  <= 1'b0;
            brick_row <= '0;
        end else begin
            brick_px  <= px_hit;
            brick_row <= px_row;
        end
    end

endmodule
